// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: two-requester round-robin arbiter in front of a small
// flip-flop register bank. At most one read or write is granted per clock.
// Writes commit on the granting edge. Read data is registered one cycle
// later and tagged with the id of the requester that issued the read.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   reqN_valid/we/addr/wdata  operation from requester N (N = 0, 1)
//   reqN_ready                combinational grant to requester N
//   rdata, rdata_valid        registered read data and its 1-cycle strobe
//   rdata_id                  requester that issued the returned read
//   parity_err                stored-parity mismatch on the returned read
//                             (exists only when BANK_PARITY_EN is defined)
//
// Optional feature macro: BANK_PARITY_EN adds an even-parity bit per register.
module dff_bank_arbiter #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req0_we,
    input  logic [AW-1:0]    req0_addr,
    input  logic [WIDTH-1:0] req0_wdata,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic             req1_we,
    input  logic [AW-1:0]    req1_addr,
    input  logic [WIDTH-1:0] req1_wdata,
    output logic             req1_ready,
    output logic [WIDTH-1:0] rdata,
    output logic             rdata_valid,
`ifdef BANK_PARITY_EN
    output logic             parity_err,
`endif
    output logic             rdata_id
);

    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    logic             ptr;
    logic             grant0;
    logic             grant1;
    logic             gnt;
    logic             g_we;
    logic [AW-1:0]    g_addr;
    logic [WIDTH-1:0] g_wdata;
    logic             in_range;

    logic [WIDTH-1:0] bank [DEPTH];

    // A lone valid always wins; on contention the pointer decides.
    // Nothing is granted while reset is held so nothing commits then.
    assign grant0 = !rst && req0_valid && (!req1_valid || !ptr);
    assign grant1 = !rst && req1_valid && (!req0_valid ||  ptr);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign gnt     = grant0 || grant1;
    assign g_we    = grant1 ? req1_we    : req0_we;
    assign g_addr  = grant1 ? req1_addr  : req0_addr;
    assign g_wdata = grant1 ? req1_wdata : req0_wdata;

    // Only meaningful for non-power-of-two DEPTH.
    assign in_range = {1'b0, g_addr} < DEPTH_V;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            rdata_id    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else begin
            rdata_valid <= gnt && !g_we;
            if (gnt) begin
                ptr <= ~grant1;
                if (g_we) begin
                    if (in_range) begin
                        bank[g_addr] <= g_wdata;
                    end
                end else begin
                    rdata    <= in_range ? bank[g_addr] : '0;
                    rdata_id <= grant1;
                end
            end
        end
    end

`ifdef BANK_PARITY_EN
    logic [DEPTH-1:0] par_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q      <= '0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            if (gnt && in_range) begin
                if (g_we) begin
                    par_q[g_addr] <= ^g_wdata;
                end else begin
                    parity_err <= par_q[g_addr] != ^bank[g_addr];
                end
            end
        end
    end
`endif

endmodule
